// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: six-phase NS/EW intersection sequencer with a per-phase tick countdown.
// Define PED_REQUEST_EN to enable pedestrian-request green truncation.
module traffic_phase_timer #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned GREEN_S     = 35,
    parameter int unsigned YELLOW_S    = 5,
    parameter int unsigned ALL_RED_S   = 1,
    parameter int unsigned PED_GREEN_S = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        ped_req,
    output logic [31:0] clock_ticks,
    output logic [2:0]  ns_light,
    output logic [2:0]  ew_light,
    output logic        phase_done
);

    localparam int unsigned TW = 32;

    localparam logic [63:0] LEN_MAX       = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] GREEN_LEN64   = 64'(GREEN_S) * 64'(CLK_HZ);
    localparam logic [63:0] YELLOW_LEN64  = 64'(YELLOW_S) * 64'(CLK_HZ);
    localparam logic [63:0] ALL_RED_LEN64 = 64'(ALL_RED_S) * 64'(CLK_HZ);
    localparam logic [63:0] PED_LEN64     = 64'(PED_GREEN_S) * 64'(CLK_HZ);

    localparam logic [TW-1:0] GREEN_LOAD   = TW'(GREEN_LEN64 - 64'd1);
    localparam logic [TW-1:0] YELLOW_LOAD  = TW'(YELLOW_LEN64 - 64'd1);
    localparam logic [TW-1:0] ALL_RED_LOAD = TW'(ALL_RED_LEN64 - 64'd1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Reject configurations whose phase lengths are zero or do not fit the 32-bit counter
    if (GREEN_S == 0 || YELLOW_S == 0 || ALL_RED_S == 0 || PED_GREEN_S == 0) begin : g_zero_len
        $error("traffic_phase_timer: all phase lengths in seconds must be non-zero");
    end
    if (GREEN_LEN64 > LEN_MAX || YELLOW_LEN64 > LEN_MAX ||
        ALL_RED_LEN64 > LEN_MAX || PED_LEN64 > LEN_MAX) begin : g_len_ovf
        $error("traffic_phase_timer: a phase length exceeds 2^32-1 ticks");
    end

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_B     = 3'd5
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [TW-1:0]   ticks_d;
    logic [2:0]      ns_d;
    logic [2:0]      ew_d;
    logic            done_d;

`ifdef PED_REQUEST_EN
    localparam logic [TW-1:0] PED_LOAD = TW'(PED_LEN64 - 64'd1);

    logic ped_flag;
    logic ped_pending;
    logic in_green;
    logic enter_yellow;

    assign in_green     = (state_q == NS_GREEN) || (state_q == EW_GREEN);
    assign ped_pending  = ped_flag || ped_req;
    assign enter_yellow = run && in_green && (clock_ticks == '0);

    // Sticky request; keeps sampling while run=0, dropped when the green ends
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ped_flag <= 1'b0;
        end else if (enter_yellow) begin
            ped_flag <= 1'b0;
        end else if (ped_req) begin
            ped_flag <= 1'b1;
        end
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    // Next state, next count and next lamp pattern
    always_comb begin
        state_d = state_q;
        ticks_d = clock_ticks;
        done_d  = 1'b0;
        ns_d    = LAMP_RED;
        ew_d    = LAMP_RED;

        if (run) begin
            if (clock_ticks == '0) begin
                done_d = 1'b1;
                case (state_q)
                    NS_GREEN:  begin state_d = NS_YELLOW; ticks_d = YELLOW_LOAD;  end
                    NS_YELLOW: begin state_d = RED_A;     ticks_d = ALL_RED_LOAD; end
                    RED_A:     begin state_d = EW_GREEN;  ticks_d = GREEN_LOAD;   end
                    EW_GREEN:  begin state_d = EW_YELLOW; ticks_d = YELLOW_LOAD;  end
                    EW_YELLOW: begin state_d = RED_B;     ticks_d = ALL_RED_LOAD; end
                    RED_B:     begin state_d = NS_GREEN;  ticks_d = GREEN_LOAD;   end
                    default:   begin state_d = RED_B;     ticks_d = ALL_RED_LOAD; end
                endcase
            end
`ifdef PED_REQUEST_EN
            else if (in_green && ped_pending && (clock_ticks > PED_LOAD)) begin
                ticks_d = PED_LOAD;
            end
`endif
            else begin
                ticks_d = clock_ticks - TW'(1);
            end
        end

        case (state_d)
            NS_GREEN:  ns_d = LAMP_GREEN;
            NS_YELLOW: ns_d = LAMP_YELLOW;
            EW_GREEN:  ew_d = LAMP_GREEN;
            EW_YELLOW: ew_d = LAMP_YELLOW;
            default:   ;
        endcase
    end

    // State, count and lamps all move on the same edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RED_B;
            clock_ticks <= ALL_RED_LOAD;
            ns_light    <= LAMP_RED;
            ew_light    <= LAMP_RED;
            phase_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clock_ticks <= ticks_d;
            ns_light    <= ns_d;
            ew_light    <= ew_d;
            phase_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Scoreboard bench for traffic_phase_timer: a table-driven phase model predicts every cycle.
module tb_traffic_phase_timer;

    localparam int unsigned CLK_HZ      = 10;
    localparam int unsigned GREEN_S     = 35;
    localparam int unsigned YELLOW_S    = 5;
    localparam int unsigned ALL_RED_S   = 1;
    localparam int unsigned PED_GREEN_S = 5;
`ifdef PED_REQUEST_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    localparam int unsigned PED_LEN = PED_GREEN_S * CLK_HZ;
    localparam int unsigned LENS [6] = '{GREEN_S * CLK_HZ, YELLOW_S * CLK_HZ, ALL_RED_S * CLK_HZ,
                                         GREEN_S * CLK_HZ, YELLOW_S * CLK_HZ, ALL_RED_S * CLK_HZ};
    localparam logic [2:0] NS_TAB [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    localparam logic [2:0] EW_TAB [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    typedef struct packed {
        logic [31:0] ticks;
        logic [2:0]  ns;
        logic [2:0]  ew;
        logic        done;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        run;
    logic        ped_req;
    logic [31:0] clock_ticks;
    logic [2:0]  ns_light;
    logic [2:0]  ew_light;
    logic        phase_done;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    // model: phase index into the tables, ticks left, pending request
    int          m_phase;
    int unsigned m_rem;
    bit          m_flag;
    bit          m_done;

    traffic_phase_timer #(
        .CLK_HZ(CLK_HZ), .GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S),
        .ALL_RED_S(ALL_RED_S), .PED_GREEN_S(PED_GREEN_S)
    ) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .ped_req(ped_req),
        .clock_ticks(clock_ticks), .ns_light(ns_light), .ew_light(ew_light),
        .phase_done(phase_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rn, input bit r, input bit p);
        bit req;
        bit green;
        bit to_yellow;
        req       = PED_EN && (m_flag || p);
        green     = (m_phase == 0) || (m_phase == 3);
        to_yellow = 1'b0;
        m_done    = 1'b0;
        if (!rn) begin
            m_phase = 5;
            m_rem   = LENS[5] - 1;
            m_flag  = 1'b0;
        end else begin
            if (r) begin
                if (m_rem == 0) begin
                    to_yellow = green;
                    m_phase   = (m_phase + 1) % 6;
                    m_rem     = LENS[m_phase] - 1;
                    m_done    = 1'b1;
                end else if (green && req && m_rem > PED_LEN - 1) begin
                    m_rem = PED_LEN - 1;
                end else begin
                    m_rem = m_rem - 1;
                end
            end
            if (PED_EN) begin
                if (to_yellow) m_flag = 1'b0;
                else if (p)    m_flag = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT must show after the next edge
    task automatic cyc(input bit rn, input bit r, input bit p);
        exp_t e;
        @(negedge clock);
        reset_n = rn;
        run     = r;
        ped_req = p;
        model_step(rn, r, p);
        e.ticks = m_rem;
        e.ns    = NS_TAB[m_phase];
        e.ew    = EW_TAB[m_phase];
        e.done  = m_done;
        exp_q.push_back(e);
    endtask

    task automatic run_until(input int phase, input int unsigned rem);
        for (int i = 0; i < 2000 && !(m_phase == phase && m_rem == rem); i++) cyc(1'b1, 1'b1, 1'b0);
    endtask

    task automatic sample_next();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every edge presents a new output word
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("clock_ticks", clock_ticks, e.ticks);
                chk("lamps", 32'({ns_light, ew_light}), 32'({e.ns, e.ew}));
                chk("phase_done", 32'(phase_done), 32'(e.done));
                chk("one_road_red", 32'(ns_light[2] | ew_light[2]), 32'd1);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        run     = 1'b0;
        ped_req = 1'b0;
        model_step(1'b0, 1'b0, 1'b0);

        // reset then release with run=1
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        chk("reset_ticks", clock_ticks, 32'd9);
        chk("reset_lamps", 32'({ns_light, ew_light}), 32'h24);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);
        sample_next();
        chk("first_green_done", 32'(phase_done), 32'd1);
        chk("first_green_ns", 32'(ns_light), 32'd1);
        chk("first_green_ticks", clock_ticks, 32'd349);

        // hold mid NS_GREEN
        run_until(0, 200);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0);
        sample_next();
        chk("hold_ticks", clock_ticks, 32'd200);
        cyc(1'b1, 1'b1, 1'b0);
        sample_next();
        chk("resume_ticks", clock_ticks, 32'd199);

        // asynchronous reset mid EW_YELLOW
        run_until(4, 30);
        cyc(1'b0, 1'b1, 1'b0);
        #1;
        chk("async_rst_ticks", clock_ticks, 32'd9);
        chk("async_rst_lamps", 32'({ns_light, ew_light}), 32'h24);
        chk("async_rst_done", 32'(phase_done), 32'd0);
        cyc(1'b0, 1'b1, 1'b0);

        // pedestrian request early and late in NS_GREEN
        run_until(0, 300);
        cyc(1'b1, 1'b1, 1'b1);
        sample_next();
        chk("ped_truncate", clock_ticks, PED_EN ? 32'd49 : 32'd299);
        run_until(0, 20);
        cyc(1'b1, 1'b1, 1'b1);
        sample_next();
        chk("ped_late", clock_ticks, 32'd19);

        // request during RED_A carried into EW_GREEN
        run_until(2, 5);
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 50 && m_phase != 3; i++) cyc(1'b1, 1'b1, 1'b0);
        sample_next();
        chk("ew_green_load", clock_ticks, 32'd349);
        cyc(1'b1, 1'b1, 1'b0);
        sample_next();
        chk("ew_ped_truncate", clock_ticks, PED_EN ? 32'd49 : 32'd348);

        // random run / ped_req / occasional reset
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 399) != 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 29) == 0));
        end
        cyc(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) sample_next();
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
